// File: rtl/alu_input_ctrl_if.sv
// Button/switch inputs and ALU control outputs of the board ALU front end.
// The bench drives through master; the design sits on slave.
interface alu_input_ctrl_if;
  logic [2:0] button;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [2:0] mode;
  logic       enable;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic [2:0] btn_pulse;

  modport master (
    output button, a_in, b_in,
    input  mode, enable, a_out, b_out, btn_pulse
  );

  modport slave (
    input  button, a_in, b_in,
    output mode, enable, a_out, b_out, btn_pulse
  );
endinterface

// File: rtl/alu_input_ctrl.sv
// ALU front end: per-button sync + debounce + press pulse, mode/enable control
// and operand capture on the enable rising edge.
module alu_input_ctrl_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2, stable;
  logic [CW-1:0] cnt;

  // Any cycle agreeing with the accepted level restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      pulse <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        stable <= s2;
        cnt    <= '0;
        pulse  <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module alu_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic             clk,
  input logic             rst,
  alu_input_ctrl_if.slave bus
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 4;

  logic [NUM_LANES-1:0]        pulse;
  logic [1:0][VEC_W-1:0]       sw_s1, sw_s2;
  logic [2:0]                  mode, mode_nxt;
  logic                        enable, en_nxt, capture;
  logic [VEC_W-1:0]            a_q, b_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    alu_input_ctrl_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.button[i]),
      .pulse (pulse[i])
    );
  end

  // Enable toggle wins over mode buttons; both mode buttons together only drop enable.
  always_comb begin
    mode_nxt = mode;
    en_nxt   = enable;
    capture  = 1'b0;
    if (pulse[2]) begin
      en_nxt  = ~enable;
      capture = ~enable;
    end else if (pulse == 3'b010) begin
      mode_nxt = mode + 3'd1;
      en_nxt   = 1'b0;
    end else if (pulse == 3'b001) begin
      mode_nxt = mode - 3'd1;
      en_nxt   = 1'b0;
    end else if (pulse == 3'b011) begin
      en_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      mode   <= '0;
      enable <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      sw_s1  <= {bus.b_in, bus.a_in};
      sw_s2  <= sw_s1;
      mode   <= mode_nxt;
      enable <= en_nxt;
      if (capture) begin
        a_q <= sw_s2[0];
        b_q <= sw_s2[1];
      end
    end
  end

  assign bus.mode      = mode;
  assign bus.enable    = enable;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.btn_pulse = pulse;
endmodule

// File: tb/tb_alu_input_ctrl.sv
// Bench for alu_input_ctrl: constant vector table, directed corner sequences
// and random stimulus against a cycle-level behavioural model.
module tb_alu_input_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_input_ctrl_if bus ();
  alu_input_ctrl #(.DEBOUNCE_CYCLES(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [2:0] bq[$];
  logic [7:0] sq[$];
  int         mis[3];
  logic [2:0] st_m, pulse_m, mode_m;
  logic       en_m;
  logic [3:0] a_m, b_m;

  logic [3:0] sw_a = 4'h0, sw_b = 4'h0;
  int         pcnt[3];
  logic [2:0] seen;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Sync is a two-deep delay line; a level is accepted after N consecutive
  // disagreeing samples; control acts on the previous cycle's pulses.
  task automatic model_edge(input logic r, input logic [2:0] btn, input logic [7:0] sw);
    logic [2:0] s2;
    logic [7:0] sw2;
    if (r) begin
      bq = '{3'b0, 3'b0};
      sq = '{8'h0, 8'h0};
      for (int i = 0; i < 3; i++) mis[i] = 0;
      st_m = 0; pulse_m = 0; mode_m = 0; en_m = 0; a_m = 0; b_m = 0;
    end else begin
      s2  = bq[0];
      sw2 = sq[0];
      if (pulse_m[2]) begin
        if (!en_m) begin a_m = sw2[3:0]; b_m = sw2[7:4]; end
        en_m = !en_m;
      end else if (pulse_m != 3'b000) begin
        en_m = 1'b0;
        if (pulse_m == 3'b010) mode_m = mode_m + 3'd1;
        else if (pulse_m == 3'b001) mode_m = mode_m - 3'd1;
      end
      pulse_m = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == st_m[i]) mis[i] = 0;
        else begin
          mis[i]++;
          if (mis[i] == N) begin
            st_m[i] = s2[i];
            mis[i] = 0;
            pulse_m[i] = s2[i];
          end
        end
      end
      void'(bq.pop_front()); bq.push_back(btn);
      void'(sq.pop_front()); sq.push_back(sw);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] btn);
    rst = r;
    bus.button = btn;
    bus.a_in = sw_a;
    bus.b_in = sw_b;
    @(posedge clk);
    model_edge(r, btn, {sw_b, sw_a});
    #1;
    chk("model", {bus.mode, bus.enable, bus.a_out, bus.b_out, bus.btn_pulse},
        {mode_m, en_m, a_m, b_m, pulse_m});
    seen = seen | bus.btn_pulse;
    for (int i = 0; i < 3; i++) if (bus.btn_pulse[i]) pcnt[i]++;
  endtask

  task automatic press(input logic [2:0] btn);
    for (int i = 0; i < 8; i++) step(1'b0, btn);
    for (int i = 0; i < 8; i++) step(1'b0, 3'b000);
  endtask

  task automatic do_reset();
    step(1'b1, 3'b000);
    seen = 3'b000;
    for (int i = 0; i < 3; i++) pcnt[i] = 0;
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] btn;
    logic [2:0] mode;
    logic       en;
    logic [2:0] pulse;
    logic [3:0] a_out;
  } vec_t;
  vec_t tbl[22];

  initial begin
    bus.button = 3'b000; bus.a_in = 4'h0; bus.b_in = 4'h0;
    seen = 3'b000;
    for (int i = 0; i < 3; i++) pcnt[i] = 0;

    // button[1] held for 12 edges then released; pulse on edge 5, mode at 6
    tbl[0] = '{1'b1, 3'b000, 3'd0, 1'b0, 3'b000, 4'h0};
    for (int k = 0; k < 21; k++)
      tbl[k+1] = '{1'b0, (k < 12) ? 3'b010 : 3'b000, (k >= 6) ? 3'd1 : 3'd0,
                   1'b0, (k == 5) ? 3'b010 : 3'b000, 4'h0};
    sw_a = 4'h5; sw_b = 4'h9;
    for (int k = 0; k < 22; k++) begin
      step(tbl[k].rst, tbl[k].btn);
      chk($sformatf("tbl%0d", k), {bus.mode, bus.enable, bus.btn_pulse, bus.a_out},
          {tbl[k].mode, tbl[k].en, tbl[k].pulse, tbl[k].a_out});
    end

    // bounce shorter than the window
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 3'b010);
    step(1'b0, 3'b000);
    for (int i = 0; i < 3; i++) step(1'b0, 3'b010);
    for (int i = 0; i < 10; i++) step(1'b0, 3'b000);
    chk("bounce_pulse", seen, 3'b000);
    chk("bounce_mode", bus.mode, 3'd0);

    // wrap both ways
    do_reset();
    press(3'b001);
    chk("mode_down_wrap", bus.mode, 3'd7);
    do_reset();
    for (int i = 0; i < 8; i++) press(3'b010);
    chk("mode_up_wrap", bus.mode, 3'd0);
    chk("up_pulses", pcnt[1], 8);

    // operand capture and hold
    do_reset();
    sw_a = 4'b1010; sw_b = 4'b0011;
    press(3'b100);
    chk("cap_en", bus.enable, 1'b1);
    chk("cap_ab", {bus.a_out, bus.b_out}, 8'hA3);
    sw_a = 4'h0; sw_b = 4'h0;
    for (int i = 0; i < 10; i++) step(1'b0, 3'b000);
    chk("hold_ab", {bus.a_out, bus.b_out}, 8'hA3);
    press(3'b010);
    chk("up_clears_en", {bus.mode, bus.enable}, {3'd1, 1'b0});
    chk("hold_ab2", {bus.a_out, bus.b_out}, 8'hA3);

    // simultaneous presses
    do_reset();
    press(3'b100);
    chk("sim_en_on", bus.enable, 1'b1);
    press(3'b011);
    chk("both_mode", {bus.mode, bus.enable}, {3'd0, 1'b0});
    press(3'b100);
    press(3'b111);
    chk("all_three", {bus.mode, bus.enable}, {3'd0, 1'b0});

    // reset in the middle of a held enable press
    do_reset();
    press(3'b010);
    sw_a = 4'h5; sw_b = 4'h6;
    for (int i = 0; i < 3; i++) step(1'b0, 3'b100);
    step(1'b1, 3'b100);
    chk("mid_rst", {bus.mode, bus.enable, bus.a_out, bus.b_out, bus.btn_pulse}, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 3'b100);
    chk("rst_en_early", bus.enable, 1'b0);
    step(1'b0, 3'b100);
    chk("rst_en_edge6", bus.enable, 1'b1);
    chk("rst_cap", {bus.a_out, bus.b_out}, 8'h56);

    // random held levels of random length, occasional reset
    do_reset();
    for (int seg = 0; seg < 400; seg++) begin
      logic [2:0] b;
      int hold;
      b = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 9);
      sw_a = 4'($urandom); sw_b = 4'($urandom);
      for (int i = 0; i < hold; i++) step(($urandom_range(0, 150) == 0), b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
